data_sram_slave: RTL and testbench
==================================

# data_sram_slave

Data-side SRAM responder for the MIPS core's memory-stage port: it accepts the byte-enabled requests the pipeline issues (enable, 4-bit write strobe, byte address, write data) and returns read data. It holds a word-organised on-chip data memory and can insert a configurable number of wait states, signalled to the pipeline as a stall. It sits between the CPU top level and the data memory space, after the pipeline's own address translation.

## Interface
- ADDR_W, 12: word-index width; depth = 2^ADDR_W words (default 16 KB).
- WAIT, 0: wait states per access, 0..15; 0 means single-cycle.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  request valid; the requester holds en/wen/addr/wdata stable while stall is high.
- wen  in  4  byte write strobes; wen[i] writes wdata[8i+7:8i]; 4'b0000 means read.
- addr  in  32  byte address; addr[1:0] ignored, addr[ADDR_W+1:2] is the word index, upper bits ignored (aliasing).
- wdata  in  32  write data, lane-aligned.
- rdata  out  32  registered read data.
- stall  out  1  request not yet completing; the pipeline freezes M-stage and earlier.
- proto_err  out  1  sticky protocol-violation flag (see Configuration).

## Operation
- States: IDLE, BUSY. 4-bit counter cnt.
- IDLE, en=0: nothing happens; rdata holds its value.
- IDLE, en=1, WAIT=0: access is performed at this edge; state stays IDLE.
- IDLE, en=1, WAIT>0: latch wen/addr/wdata; cnt<=WAIT; go to BUSY.
- BUSY: cnt decrements every cycle. When cnt==1 the access is performed from the latched request at this edge, then the block returns to IDLE.
- Access: rdata<=mem[idx] using the pre-write word (read-first), for both reads and writes. Each lane with wen[i]=1 is updated from wdata. Lanes with wen[i]=0 are untouched.
- Once accepted, a request always completes. There is no abort, except by reset.
- Memory contents are not cleared by reset.

## Timing
- stall (combinational) = (IDLE & en & WAIT!=0) | (BUSY & cnt!=1).
- A request occupies WAIT+1 cycles. stall is high during the first WAIT of them and low in the final cycle.
- rdata is valid in the cycle after the final (stall-low) request cycle. Write data is visible to a read issued in that same following cycle.
- Back-to-back requests: a new en in IDLE immediately after completion is accepted with no bubble.
- Reset values: rdata=0, stall=0, proto_err=0, state=IDLE, cnt=0.
- Reset while in BUSY: the latched request is discarded and no memory write occurs.

## Configuration
- DSRAM_PROTO_CHECK_EN defined:
  - proto_err is set in any BUSY cycle where en=0, or where wen/addr[ADDR_W+1:2]/wdata differ from the latched copy.
  - proto_err stays set until reset.
  - The access still uses the latched values.
- Not defined: proto_err is tied to 0 and the comparison logic is absent. The port exists in both builds.

## Test plan
- WAIT=0: write 0x11223344 to 0x100 with wen=4'hF, then read 0x100 → stall never high; rdata=0x11223344 the cycle after the read.
- WAIT=0: prior word 0xAABBCCDD at 0x104, write wen=4'b0010 with wdata=0x0000EE00, then read → rdata=0xAABBEEDD; the write cycle itself returns 0xAABBCCDD next cycle (read-first).
- WAIT=3: read 0x200 holding 0xCAFEF00D → stall high for exactly 3 cycles, low on the 4th; rdata=0xCAFEF00D on the 5th; back-to-back second read stalls another 3 cycles.
- WAIT=2, ADDR_W=12: write 0x5A5A5A5A to 0x0000_4008, then read 0x0000_0008 → rdata=0x5A5A5A5A (aliasing).
- WAIT=3: assert rst in the 2nd cycle of a write of 0xFFFFFFFF to 0x300 (previous content 0x0) → stall=0 and rdata=0 next cycle; a later read of 0x300 returns 0x0.
- With DSRAM_PROTO_CHECK_EN and WAIT=2: change addr during a stalled cycle → proto_err=1 the next cycle and stays 1 until rst; the write lands at the originally latched address.

Source files
------------

// File: rtl/data_sram_slave.sv
// Data-side SRAM responder with optional wait states (stall) and read-first byte-lane writes.
// Optional build macro DSRAM_PROTO_CHECK_EN enables the sticky protocol-violation flag.
module data_sram_slave #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WAIT   = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [3:0]  wen_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        proto_err_o
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam logic [3:0]  WaitCnt = 4'(WAIT);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          wen_q, wen_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q;
  logic [31:0]         mem_q [Depth];

  logic [ADDR_W-1:0]   idx_in;
  logic                acc_en;
  logic [3:0]          acc_wen;
  logic [ADDR_W-1:0]   acc_idx;
  logic [31:0]         acc_wdata;

  // Upper address bits alias; byte offset is ignored.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};
  assign idx_in      = addr_i[ADDR_W+1:2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wen_d     = wen_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    acc_en    = 1'b0;
    acc_wen   = wen_i;
    acc_idx   = idx_in;
    acc_wdata = wdata_i;
    stall_o   = 1'b0;
    case (state_q)
      StIdle: begin
        if (en_i) begin
          if (WaitCnt == 4'd0) begin
            acc_en = 1'b1;
          end else begin
            wen_d   = wen_i;
            idx_d   = idx_in;
            wdata_d = wdata_i;
            cnt_d   = WaitCnt;
            state_d = StBusy;
            stall_o = 1'b1;
          end
        end
      end
      StBusy: begin
        cnt_d     = cnt_q - 4'd1;
        acc_wen   = wen_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        if (cnt_q == 4'd1) begin
          acc_en  = 1'b1;
          state_d = StIdle;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wen_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      if (acc_en) rdata_q <= mem_q[acc_idx];
    end
  end

  // Memory is not reset; a reset edge suppresses any pending write.
  always_ff @(posedge clk_i) begin
    if (acc_en && !rst_i) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wen[i]) mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

`ifdef DSRAM_PROTO_CHECK_EN
  logic proto_hit;
  logic proto_err_q;

  always_comb begin
    proto_hit = (state_q == StBusy) &&
                (!en_i || (wen_i != wen_q) || (idx_in != idx_q) || (wdata_i != wdata_q));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) proto_err_q <= 1'b0;
    else       proto_err_q <= proto_err_q | proto_hit;
  end

  assign proto_err_o = proto_err_q;
`else
  assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_data_sram_slave.sv
// Self-checking bench: a zero-wait and a three-wait instance checked against an
// associative-array memory model with directed and random accesses.
module tb_data_sram_slave;

  localparam int unsigned AW = 12;

`ifdef DSRAM_PROTO_CHECK_EN
  localparam logic PExp = 1'b1;
`else
  localparam logic PExp = 1'b0;
`endif

  logic clk;
  logic rst0, en0, stall0, perr0;
  logic rst3, en3, stall3, perr3;
  logic [3:0]  wen0, wen3;
  logic [31:0] addr0, wdata0, rdata0, addr3, wdata3, rdata3;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl0 [int];
  logic [31:0] mdl3 [int];

  data_sram_slave #(.ADDR_W(AW), .WAIT(0)) u_w0 (
    .clk_i(clk), .rst_i(rst0), .en_i(en0), .wen_i(wen0), .addr_i(addr0),
    .wdata_i(wdata0), .rdata_o(rdata0), .stall_o(stall0), .proto_err_o(perr0)
  );

  data_sram_slave #(.ADDR_W(AW), .WAIT(3)) u_w3 (
    .clk_i(clk), .rst_i(rst3), .en_i(en3), .wen_i(wen3), .addr_i(addr3),
    .wdata_i(wdata3), .rdata_o(rdata3), .stall_o(stall3), .proto_err_o(perr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % (32'd1 << AW));
  endfunction

  function automatic logic get_stall(input int d);
    return (d == 0) ? stall0 : stall3;
  endfunction

  // One complete request: counts stall cycles, then checks read-first data next cycle.
  task automatic access(input int d, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] wd);
    int n;
    int idx;
    bit known;
    logic [31:0] old, nw;
    idx   = widx(a);
    known = (d == 0) ? mdl0.exists(idx) : mdl3.exists(idx);
    old   = 32'd0;
    if (known) old = (d == 0) ? mdl0[idx] : mdl3[idx];
    if (d == 0) begin en0 = 1'b1; wen0 = w; addr0 = a; wdata0 = wd; end
    else        begin en3 = 1'b1; wen3 = w; addr3 = a; wdata3 = wd; end
    n = 0;
    #1;
    while (get_stall(d) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check((d == 0) ? "stall_cycles_w0" : "stall_cycles_w3", n, (d == 0) ? 0 : 3);
    nw = old;
    for (int i = 0; i < 4; i++) if (w[i]) nw[8*i +: 8] = wd[8*i +: 8];
    if (known || w == 4'hF) begin
      if (d == 0) mdl0[idx] = nw;
      else        mdl3[idx] = nw;
    end
    @(negedge clk);
    if (known) check((d == 0) ? "rdata_w0" : "rdata_w3", (d == 0) ? rdata0 : rdata3, old);
    if (d == 0) en0 = 1'b0;
    else        en3 = 1'b0;
  endtask

  initial begin
    logic [31:0] a, held;
    int n;
    rst0 = 1'b1; rst3 = 1'b1;
    en0 = 1'b0; wen0 = 4'h0; addr0 = 32'd0; wdata0 = 32'd0;
    en3 = 1'b0; wen3 = 4'h0; addr3 = 32'd0; wdata3 = 32'd0;
    repeat (2) @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0;
    check("reset_rdata_w0", rdata0, 32'd0);
    check("reset_stall_w0", {31'd0, stall0}, 32'd0);
    check("reset_perr_w0", {31'd0, perr0}, 32'd0);
    check("reset_rdata_w3", rdata3, 32'd0);
    check("reset_stall_w3", {31'd0, stall3}, 32'd0);
    check("reset_perr_w3", {31'd0, perr3}, 32'd0);

    // Zero-wait directed: full write/read, then read-first partial lane write.
    access(0, 4'hF, 32'h100, 32'h1122_3344);
    access(0, 4'h0, 32'h100, 32'h0);
    check("w0_read_100", rdata0, 32'h1122_3344);
    access(0, 4'hF, 32'h104, 32'hAABB_CCDD);
    access(0, 4'b0010, 32'h104, 32'h0000_EE00);
    check("w0_partial_old", rdata0, 32'hAABB_CCDD);
    access(0, 4'h0, 32'h104, 32'h0);
    check("w0_partial_new", rdata0, 32'hAABB_EEDD);
    held = rdata0;
    repeat (2) @(negedge clk);
    check("w0_idle_hold", rdata0, held);

    // Wait-state directed: back-to-back reads and aliasing.
    access(3, 4'hF, 32'h200, 32'hCAFE_F00D);
    access(3, 4'h0, 32'h200, 32'h0);
    check("w3_read_200", rdata3, 32'hCAFE_F00D);
    access(3, 4'h0, 32'h200, 32'h0);
    access(3, 4'hF, 32'h0000_4008, 32'h5A5A_5A5A);
    access(3, 4'h0, 32'h0000_0008, 32'h0);
    check("w3_alias", rdata3, 32'h5A5A_5A5A);

    // Random traffic over a small set of words with aliased upper bits.
    for (int k = 0; k < 8; k++) begin
      access(0, 4'hF, 32'h800 + 32'(4 * k), $urandom);
      access(3, 4'hF, 32'h800 + 32'(4 * k), $urandom);
    end
    for (int t = 0; t < 30; t++) begin
      for (int d = 0; d < 4; d += 3) begin
        a = 32'h800 + 32'(4 * $urandom_range(0, 7));
        a = a | (32'($urandom_range(0, 3)) << 14) | 32'($urandom_range(0, 3));
        access(d, 4'($urandom_range(0, 15)), a, $urandom);
      end
    end

    // Protocol violation: address changes while stalled; write must land at the latched address.
    access(3, 4'hF, 32'h500, 32'h1234_5678);
    access(3, 4'hF, 32'h504, 32'h9ABC_DEF0);
    access(3, 4'hF, 32'h300, 32'h0);
    en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h500; wdata3 = 32'h600D_F00D;
    @(negedge clk);
    addr3 = 32'h504;
    @(negedge clk);
    check("proto_set", {31'd0, perr3}, {31'd0, PExp});
    n = 0;
    #1;
    while (stall3 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("proto_stall_end", {31'd0, stall3}, 32'd0);
    @(negedge clk);
    en3 = 1'b0;
    mdl3[widx(32'h500)] = 32'h600D_F00D;
    access(3, 4'h0, 32'h500, 32'h0);
    check("proto_latched_addr", rdata3, 32'h600D_F00D);
    access(3, 4'h0, 32'h504, 32'h0);
    check("proto_other_addr", rdata3, 32'h9ABC_DEF0);
    check("proto_sticky", {31'd0, perr3}, {31'd0, PExp});
    check("proto_w0_clear", {31'd0, perr0}, 32'd0);

    // Reset during a stalled write discards it.
    en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h300; wdata3 = 32'hFFFF_FFFF;
    @(negedge clk);
    rst3 = 1'b1; en3 = 1'b0;
    @(negedge clk);
    check("rst_busy_stall", {31'd0, stall3}, 32'd0);
    check("rst_busy_rdata", rdata3, 32'd0);
    check("rst_busy_perr", {31'd0, perr3}, 32'd0);
    rst3 = 1'b0;
    access(3, 4'h0, 32'h300, 32'h0);
    check("rst_no_write", rdata3, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
